// File: rtl/counter_seq_pkg.sv
// rtl/counter_seq_pkg.sv - shared widths, direction encodings and FSM states for the counter sequencer
package counter_seq_pkg;

   localparam int WIDTH    = 4;
   localparam int ROUNDS_W = 4;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/counter_core_4bit.sv
// rtl/counter_core_4bit.sv - loadable up/down counter, load has priority over enable
module counter_core_4bit
   import counter_seq_pkg::*;
#(
   parameter int CW = WIDTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          ld,
   input  logic          dir,
   input  logic [CW-1:0] ld_val,
   output logic [CW-1:0] count
);

   localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

   // Natural modulo-2^CW wrap in both directions.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (ld) begin
         count <= ld_val;
      end else if (en) begin
         count <= (dir == DIR_DOWN) ? (count - ONE) : (count + ONE);
      end
   end

endmodule

// File: rtl/counter_sequencer_4bit.sv
// rtl/counter_sequencer_4bit.sv - sequences the loadable counter through a programmed multi-pass run
module counter_sequencer_4bit
   import counter_seq_pkg::*;
#(
   parameter int WIDTH    = counter_seq_pkg::WIDTH,
   parameter int ROUNDS_W = counter_seq_pkg::ROUNDS_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                stop,
   input  logic                cfg_dir,
   input  logic [WIDTH-1:0]    cfg_load,
   input  logic [WIDTH-1:0]    cfg_term,
   input  logic [ROUNDS_W-1:0] cfg_rounds,
   output logic [WIDTH-1:0]    count,
   output logic                busy,
   output logic                tc_pulse,
   output logic                done,
   output logic [ROUNDS_W-1:0] round_cnt
);

   localparam logic [ROUNDS_W-1:0] ONE_R = {{(ROUNDS_W-1){1'b0}}, 1'b1};

   state_t state, state_nx;

   logic                dir_sh;
   logic [WIDTH-1:0]    load_sh;
   logic [WIDTH-1:0]    term_sh;
   logic [ROUNDS_W-1:0] rounds_sh;

   logic                capture;
   logic                core_en;
   logic                core_ld;
   logic                tc_nx;
   logic [ROUNDS_W-1:0] round_nx;
   logic                at_term;
   logic                last_pass;

   assign at_term   = (count == term_sh);
   assign last_pass = (rounds_sh != '0) && ((round_cnt + ONE_R) == rounds_sh);

   always_comb begin
      state_nx = state;
      capture  = 1'b0;
      core_en  = 1'b0;
      core_ld  = 1'b0;
      tc_nx    = 1'b0;
      round_nx = round_cnt;
      unique case (state)
         ST_IDLE: begin
            if (start && !stop) begin
               capture  = 1'b1;
               state_nx = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (stop) begin
               state_nx = ST_IDLE;
            end else begin
               core_ld  = 1'b1;
               round_nx = '0;
               state_nx = ST_RUN;
            end
         end
         ST_RUN: begin
            if (stop) begin
               state_nx = ST_IDLE;
            end else if (!at_term) begin
               core_en = 1'b1;
            end else begin
               // Pass boundary: round_cnt wraps naturally in continuous mode.
               tc_nx    = 1'b1;
               round_nx = round_cnt + ONE_R;
               if (last_pass) begin
                  state_nx = ST_DONE;
               end else begin
                  core_ld = 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         round_cnt <= '0;
         busy      <= 1'b0;
         tc_pulse  <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nx;
         round_cnt <= round_nx;
         busy      <= (state_nx == ST_LOAD) || (state_nx == ST_RUN);
         tc_pulse  <= tc_nx;
         done      <= (state_nx == ST_DONE);
      end
   end

   // Configuration is frozen at launch so a run ignores later cfg changes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dir_sh    <= DIR_UP;
         load_sh   <= '0;
         term_sh   <= '0;
         rounds_sh <= '0;
      end else if (capture) begin
         dir_sh    <= cfg_dir;
         load_sh   <= cfg_load;
         term_sh   <= cfg_term;
         rounds_sh <= cfg_rounds;
      end
   end

   counter_core_4bit #(
      .CW (WIDTH)
   ) u_core (
      .clk    (clk),
      .rst    (rst),
      .en     (core_en),
      .ld     (core_ld),
      .dir    (dir_sh),
      .ld_val (load_sh),
      .count  (count)
   );

endmodule

// File: tb/tb_counter_sequencer_4bit.sv
// tb/tb_counter_sequencer_4bit.sv - self-checking bench for counter_sequencer_4bit
module tb_counter_sequencer_4bit;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       cfg_dir = 1'b0;
   logic [3:0] cfg_load = 4'd0;
   logic [3:0] cfg_term = 4'd0;
   logic [3:0] cfg_rounds = 4'd0;
   logic [3:0] count;
   logic       busy;
   logic       tc_pulse;
   logic       done;
   logic [3:0] round_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [3:0] c;
      logic       b;
      logic       t;
      logic       d;
      logic [3:0] r;
   } exp_t;

   exp_t exp_q[$];

   counter_sequencer_4bit dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .cfg_dir    (cfg_dir),
      .cfg_load   (cfg_load),
      .cfg_term   (cfg_term),
      .cfg_rounds (cfg_rounds),
      .count      (count),
      .busy       (busy),
      .tc_pulse   (tc_pulse),
      .done       (done),
      .round_cnt  (round_cnt)
   );

   always #5 clk = ~clk;

   function automatic exp_t obs();
      return {count, busy, tc_pulse, done, round_cnt};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected outputs after each edge following the start edge, derived from
   // pass length arithmetic rather than state-by-state stepping.
   task automatic build(input bit d, input int l, input int t, input int r, input int maxn);
      int p;
      int rnd;
      int c;
      exp_q.delete();
      exp_q.push_back({4'(l), 1'b1, 1'b0, 1'b0, 4'd0});
      p = (d ? ((l - t + 16) % 16) : ((t - l + 16) % 16)) + 1;
      rnd = 0;
      while (exp_q.size() < maxn) begin
         for (int j = 0; j < p; j++) begin
            if (j < p - 1) begin
               c = d ? ((l - (j + 1) + 32) % 16) : ((l + j + 1) % 16);
               exp_q.push_back({4'(c), 1'b1, 1'b0, 1'b0, 4'(rnd)});
            end else begin
               rnd = (rnd + 1) % 16;
               if (r != 0 && rnd == r) begin
                  exp_q.push_back({4'(t), 1'b0, 1'b1, 1'b1, 4'(rnd)});
                  exp_q.push_back({4'(t), 1'b0, 1'b0, 1'b0, 4'(rnd)});
                  return;
               end
               exp_q.push_back({4'(l), 1'b1, 1'b1, 1'b0, 4'(rnd)});
            end
            if (exp_q.size() >= maxn) return;
         end
      end
   endtask

   task automatic launch(input bit d, input int l, input int t, input int r);
      cfg_dir    = d;
      cfg_load   = 4'(l);
      cfg_term   = 4'(t);
      cfg_rounds = 4'(r);
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #1;
      n_checks++;
      if (obs() !== '0) begin
         $display("FAIL reset_async obs=%h exp=%h", obs(), 13'h0);
         n_fail++;
      end
      @(negedge clk);
      rst = 1'b0;
      tick();
      n_checks++;
      if (obs() !== '0) begin
         $display("FAIL reset_idle obs=%h exp=%h", obs(), 13'h0);
         n_fail++;
      end
   endtask

   task automatic test_up_run_shadowed();
      build(1'b0, 3, 7, 1, 100);
      launch(1'b0, 3, 7, 1);
      n_checks++;
      if (busy !== 1'b1) begin
         $display("FAIL up_launch_busy obs=%b exp=1", busy);
         n_fail++;
      end
      foreach (exp_q[i]) begin
         start      = 1'b1;
         cfg_term   = 4'd9;
         cfg_load   = 4'($urandom_range(0, 15));
         cfg_dir    = 1'($urandom_range(0, 1));
         cfg_rounds = 4'($urandom_range(0, 15));
         tick();
         n_checks++;
         if (obs() !== exp_q[i]) begin
            $display("FAIL up_run step=%0d obs=%h exp=%h", i, obs(), exp_q[i]);
            n_fail++;
         end
      end
      start = 1'b0;
      tick();
      n_checks++;
      if ({count, busy, done} !== {4'd7, 1'b0, 1'b0}) begin
         $display("FAIL up_idle_hold obs=%h exp=%h", {count, busy, done}, {4'd7, 2'b00});
         n_fail++;
      end
   endtask

   task automatic test_down_continuous_stop();
      int done_seen = 0;
      build(1'b1, 2, 14, 0, 16);
      launch(1'b1, 2, 14, 0);
      foreach (exp_q[i]) begin
         tick();
         n_checks++;
         if (obs() !== exp_q[i]) begin
            $display("FAIL down_cont step=%0d obs=%h exp=%h", i, obs(), exp_q[i]);
            n_fail++;
         end
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      n_checks++;
      if (obs() !== {exp_q[$].c, 1'b0, 1'b0, 1'b0, exp_q[$].r}) begin
         $display("FAIL down_stop obs=%h exp=%h", obs(), {exp_q[$].c, 3'b000, exp_q[$].r});
         n_fail++;
      end
      for (int k = 0; k < 6; k++) begin
         tick();
         if (done) done_seen++;
      end
      n_checks++;
      if (done_seen !== 0 || count !== exp_q[$].c) begin
         $display("FAIL down_after_stop done_cycles=%0d count=%0d exp done_cycles=0 count=%0d",
                  done_seen, count, exp_q[$].c);
         n_fail++;
      end
   endtask

   task automatic test_multi_pass();
      int tcs = 0;
      int dns = 0;
      build(1'b0, 0, 2, 3, 100);
      launch(1'b0, 0, 2, 3);
      foreach (exp_q[i]) begin
         tick();
         if (tc_pulse) tcs++;
         if (done) dns++;
         n_checks++;
         if (obs() !== exp_q[i]) begin
            $display("FAIL multi_pass step=%0d obs=%h exp=%h", i, obs(), exp_q[i]);
            n_fail++;
         end
      end
      n_checks++;
      if (tcs !== 3 || dns !== 1 || round_cnt !== 4'd3 || count !== 4'd2) begin
         $display("FAIL multi_pass_totals tc=%0d done=%0d rounds=%0d count=%0d exp 3 1 3 2",
                  tcs, dns, round_cnt, count);
         n_fail++;
      end
   endtask

   task automatic test_async_reset_mid_run();
      launch(1'b0, 1, 12, 0);
      for (int k = 0; k < 4; k++) tick();
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (obs() !== '0) begin
         $display("FAIL async_rst_mid obs=%h exp=%h", obs(), 13'h0);
         n_fail++;
      end
      tick();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      n_checks++;
      if (obs() !== '0) begin
         $display("FAIL async_rst_idle obs=%h exp=%h", obs(), 13'h0);
         n_fail++;
      end
   endtask

   task automatic test_degenerate();
      build(1'b0, 5, 5, 2, 100);
      launch(1'b0, 5, 5, 2);
      foreach (exp_q[i]) begin
         tick();
         n_checks++;
         if (obs() !== exp_q[i]) begin
            $display("FAIL degenerate step=%0d obs=%h exp=%h", i, obs(), exp_q[i]);
            n_fail++;
         end
      end
   endtask

   task automatic test_start_stop_idle();
      logic [3:0] held;
      held  = count;
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      tick();
      n_checks++;
      if ({busy, done, count} !== {1'b0, 1'b0, held}) begin
         $display("FAIL start_stop_idle obs=%h exp=%h", {busy, done, count}, {2'b00, held});
         n_fail++;
      end
   endtask

   task automatic test_stop_in_load();
      exp_t held;
      held = obs();
      launch(1'b1, 9, 4, 2);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      n_checks++;
      if (obs() !== {held.c, 1'b0, 1'b0, 1'b0, held.r}) begin
         $display("FAIL stop_in_load obs=%h exp=%h", obs(), {held.c, 3'b000, held.r});
         n_fail++;
      end
   endtask

   task automatic test_back_to_back_random();
      int  l;
      int  t;
      int  r;
      bit  d;
      for (int it = 0; it < 8; it++) begin
         d = 1'($urandom_range(0, 1));
         l = $urandom_range(0, 15);
         t = $urandom_range(0, 15);
         r = $urandom_range(1, 3);
         build(d, l, t, r, 200);
         launch(d, l, t, r);
         foreach (exp_q[i]) begin
            cfg_load = 4'($urandom_range(0, 15));
            cfg_term = 4'($urandom_range(0, 15));
            tick();
            n_checks++;
            if (obs() !== exp_q[i]) begin
               $display("FAIL random it=%0d step=%0d obs=%h exp=%h", it, i, obs(), exp_q[i]);
               n_fail++;
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_up_run_shadowed();
      test_down_continuous_stop();
      test_multi_pass();
      test_async_reset_mid_run();
      test_degenerate();
      test_start_stop_idle();
      test_stop_in_load();
      test_back_to_back_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
